// File: rtl/mcc_seq_addsub.sv
// Multi-word sequential add/subtract: one WORD_W-bit Manchester carry chain is reused
// once per slice (LSW first), with the inter-slice carry held in a register.
module mcc_seq_addsub #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*NWORDS-1:0]   in_a,
  input  logic [WORD_W*NWORDS-1:0]   in_b,
  input  logic                       in_sub,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W*NWORDS-1:0]   out_sum,
  output logic                       out_cout,
  output logic                       out_ovf,
  output logic                       out_zero
);
  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      a_reg, b_reg;
  logic              carry;
  logic [IDX_W-1:0]  k;
  logic              last;
  logic [WORD_W-1:0] a_s, b_s, s_s, gen, prop;
  logic [WORD_W:0]   chain;
  logic [W-1:0]      sum_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (k == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last)     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Manchester chain on the current slice: generate/propagate, carry rippled through the switches
  always_comb begin
    a_s      = a_reg[k*WORD_W +: WORD_W];
    b_s      = b_reg[k*WORD_W +: WORD_W];
    gen      = a_s & b_s;
    prop     = a_s ^ b_s;
    chain    = '0;
    chain[0] = carry;
    for (int i = 0; i < WORD_W; i++) begin
      chain[i+1] = gen[i] | (prop[i] & chain[i]);
    end
    s_s      = prop ^ chain[WORD_W-1:0];
    sum_nxt  = out_sum;
    sum_nxt[k*WORD_W +: WORD_W] = s_s;
  end

  // Operand capture; B is inverted here so the chain only ever adds
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      a_reg <= in_a;
      b_reg <= in_sub ? ~in_b : in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k        <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else if (in_valid && in_ready) begin
      k     <= '0;
      carry <= in_cin ^ in_sub;
    end else if (state == CALC) begin
      out_sum <= sum_nxt;
      carry   <= chain[WORD_W];
      k       <= k + 1'b1;
      if (last) begin
        // Top slice holds the operand/result sign bits; zero covers all stored slices too
        out_cout <= chain[WORD_W];
        out_ovf  <= (a_s[WORD_W-1] == b_s[WORD_W-1]) && (s_s[WORD_W-1] != a_s[WORD_W-1]);
        out_zero <= (sum_nxt == '0);
      end
    end
  end
endmodule

// File: tb/tb_mcc_seq_addsub.sv
// Scoreboard bench for mcc_seq_addsub (WORD_W=32, NWORDS=2): directed spec cases,
// backpressure, mid-operation reset, then random operations against a W-bit model.
module tb_mcc_seq_addsub;
  localparam int WORD_W = 32;
  localparam int NWORDS = 2;
  localparam int W      = WORD_W * NWORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_sub, in_cin;
  logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0] in_a, in_b, out_sum;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mcc_seq_addsub #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin ^ sub};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency check, optional DONE stall, drain and compare
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input int stall, input exp_t e);
    int           n;
    exp_t         got;
    logic [W-1:0] snap;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("in_ready_before_op", in_ready, 1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb.push_back(e);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("latency", n, NWORDS);
    snap = out_sum;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      in_sub = 1'($urandom); in_cin = 1'($urandom);
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_sum_hold", out_sum, snap);
    end
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("sum", out_sum, got.sum);
      check("cout", out_cout, got.cout);
      check("ovf", out_ovf, got.ovf);
      check("zero", out_zero, got.zero);
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic cin, input logic [W-1:0] s, input logic co,
                          input logic ov, input logic z, input int stall);
    exp_t e;
    e.sum = s; e.cout = co; e.ovf = ov; e.zero = z;
    do_op(a, b, sub, cin, stall, e);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_flags", {out_cout, out_ovf, out_zero}, 0);

    directed(64'h0000_0000_FFFF_FFFF, 64'd1, 0, 0, 64'h0000_0001_0000_0000, 0, 0, 0, 0);
    directed(64'd5, 64'd7, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0);
    directed(64'd7, 64'd7, 1, 0, 64'd0, 1, 0, 1, 0);
    directed(64'd10, 64'd3, 1, 1, 64'd6, 1, 0, 0, 0);
    directed(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'h8000_0000_0000_0000, 0, 1, 0, 0);
    directed(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 64'd0, 1, 0, 1, 0);
    directed(64'h8000_0000_0000_0000, 64'd1, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0);
    // Backpressure: 10 stalled cycles with new operands offered, then a fresh op
    directed(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, 1,
             64'h2222_2222_2222_2212, 0, 0, 0, 10);
    directed(64'd100, 64'd1, 0, 0, 64'd101, 0, 0, 0, 0);

    // Reset in the middle of CALC: operation discarded, outputs cleared
    in_a = 64'hDEAD_BEEF_0000_0001; in_b = 64'd5; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_flags", {out_cout, out_ovf, out_zero}, 0);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    tick();
    check("midrst_no_valid", out_valid, 0);
    directed(64'd3, 64'd4, 0, 1, 64'd8, 0, 0, 0, 0);

    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] a, b;
      logic         s, c;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = ~a;
      if ($urandom_range(0, 7) == 0) b = a;
      s = 1'($urandom);
      c = 1'($urandom);
      do_op(a, b, s, c, $urandom_range(0, 2), model(a, b, s, c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
